// File: rtl/ps2_synth_pkg.sv
// Shared types and constants for the PS/2 keyboard synthesizer front end:
// note numbering, scan-code prefixes, the note lookup table and prefix FSM states.
package ps2_synth_pkg;

  localparam int NUM_NOTES = 20;

  typedef logic [4:0] note_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Entry i is the scan code that plays note i.
  localparam logic [7:0] SCAN_TABLE [NUM_NOTES] = '{
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
    8'h52, 8'h5B, 8'h4D, 8'h44, 8'h43, 8'h35, 8'h2C, 8'h24, 8'h1D, 8'h15
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BRK    = 2'd1,
    EXT    = 2'd2,
    EXTBRK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/ps2_note_decode.sv
// Combinational scan-code to note lookup; codes outside the table report is_note = 0.
module ps2_note_decode
  import ps2_synth_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       is_note,
  output note_t      note
);

  always_comb begin
    is_note = 1'b0;
    note    = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (scan_code == SCAN_TABLE[i]) begin
        is_note = 1'b1;
        note    = note_t'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_voice_allocator.sv
// Turns PS/2 make/break scan bytes into note events and maps held notes onto
// a small voice pool, stealing the oldest sounding voice when the pool is full.
module ps2_voice_allocator
  import ps2_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    scan_valid,
  input  logic [7:0]              scan_code,
  input  logic                    all_off,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [5*NUM_VOICES-1:0] voice_note,
  output logic                    evt_valid,
  output logic                    evt_on,
  output logic [2:0]              evt_voice,
  output logic [4:0]              evt_note,
  output logic                    evt_stolen
);

  localparam logic [2:0] RANK_MAX = 3'(NUM_VOICES - 1);

  prefix_state_t state_q;

  logic [NUM_VOICES-1:0] voice_on_q, voice_on_d;
  note_t                 note_q [NUM_VOICES];
  note_t                 note_d [NUM_VOICES];
  logic [2:0]            rank_q [NUM_VOICES];
  logic [2:0]            rank_d [NUM_VOICES];

  logic       evt_valid_q, evt_valid_d;
  logic       evt_on_q, evt_on_d;
  logic [2:0] evt_voice_q, evt_voice_d;
  note_t      evt_note_q, evt_note_d;
  logic       evt_stolen_q, evt_stolen_d;

  logic  dec_is_note;
  note_t dec_note;

  ps2_note_decode u_decode (
    .scan_code (scan_code),
    .is_note   (dec_is_note),
    .note      (dec_note)
  );

  logic byte_take;
  logic do_make;
  logic do_break;
  assign byte_take = scan_valid && !all_off;
  assign do_make   = byte_take && dec_is_note && (state_q == IDLE);
  assign do_break  = byte_take && dec_is_note && (state_q == BRK);

  // Priority encoders: downward scans leave the lowest matching index.
  logic       match_hit, free_hit;
  logic [2:0] match_idx, free_idx, oldest_idx, chosen_idx;
  logic [2:0] oldest_rank;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_on_q[v] && (note_q[v] == dec_note)) begin
        match_hit = 1'b1;
        match_idx = 3'(v);
      end
      if (!voice_on_q[v]) begin
        free_hit = 1'b1;
        free_idx = 3'(v);
      end
    end
    oldest_idx  = '0;
    oldest_rank = rank_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (rank_q[v] > oldest_rank) begin
        oldest_rank = rank_q[v];
        oldest_idx  = 3'(v);
      end
    end
    chosen_idx = free_hit ? free_idx : oldest_idx;
  end

  always_comb begin
    voice_on_d   = voice_on_q;
    note_d       = note_q;
    rank_d       = rank_q;
    evt_valid_d  = 1'b0;
    evt_on_d     = evt_on_q;
    evt_voice_d  = evt_voice_q;
    evt_note_d   = evt_note_q;
    evt_stolen_d = evt_stolen_q;

    if (all_off) begin
      voice_on_d = '0;
      for (int v = 0; v < NUM_VOICES; v++) rank_d[v] = '0;
    end else if (do_make && !match_hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (3'(v) == chosen_idx) begin
          voice_on_d[v] = 1'b1;
          note_d[v]     = dec_note;
          rank_d[v]     = '0;
        end else if (voice_on_q[v] && (rank_q[v] != RANK_MAX)) begin
          rank_d[v] = rank_q[v] + 3'd1;
        end
      end
      evt_valid_d  = 1'b1;
      evt_on_d     = 1'b1;
      evt_voice_d  = chosen_idx;
      evt_note_d   = dec_note;
      evt_stolen_d = !free_hit;
    end else if (do_break && match_hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (3'(v) == match_idx) voice_on_d[v] = 1'b0;
      end
      evt_valid_d  = 1'b1;
      evt_on_d     = 1'b0;
      evt_voice_d  = match_idx;
      evt_note_d   = dec_note;
      evt_stolen_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset || all_off) begin
      state_q <= IDLE;
    end else if (scan_valid) begin
      case (state_q)
        IDLE, BRK: begin
          if (scan_code == SC_BREAK)    state_q <= BRK;
          else if (scan_code == SC_EXT) state_q <= EXT;
          else                          state_q <= IDLE;
        end
        EXT:     state_q <= (scan_code == SC_BREAK) ? EXTBRK : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      voice_on_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_on_q     <= 1'b0;
      evt_voice_q  <= '0;
      evt_note_q   <= '0;
      evt_stolen_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= '0;
      end
    end else begin
      voice_on_q   <= voice_on_d;
      evt_valid_q  <= evt_valid_d;
      evt_on_q     <= evt_on_d;
      evt_voice_q  <= evt_voice_d;
      evt_note_q   <= evt_note_d;
      evt_stolen_q <= evt_stolen_d;
      note_q       <= note_d;
      rank_q       <= rank_d;
    end
  end

  assign voice_on   = voice_on_q;
  assign evt_valid  = evt_valid_q;
  assign evt_on     = evt_on_q;
  assign evt_voice  = evt_voice_q;
  assign evt_note   = evt_note_q;
  assign evt_stolen = evt_stolen_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_note_out
    assign voice_note[5*gi +: 5] = note_q[gi];
  end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed table-driven check of the PS/2 voice allocator with four voices.
module tb_ps2_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        all_off;
  logic [3:0]  voice_on;
  logic [19:0] voice_note;
  logic        evt_valid;
  logic        evt_on;
  logic [2:0]  evt_voice;
  logic [4:0]  evt_note;
  logic        evt_stolen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_voice_allocator #(.NUM_VOICES(4)) dut (
    .sys_clk    (clk),
    .reset      (rst),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .all_off    (all_off),
    .voice_on   (voice_on),
    .voice_note (voice_note),
    .evt_valid  (evt_valid),
    .evt_on     (evt_on),
    .evt_voice  (evt_voice),
    .evt_note   (evt_note),
    .evt_stolen (evt_stolen)
  );

  typedef struct {
    logic        sv;
    logic [7:0]  code;
    logic        aoff;
    logic        ev;
    logic        on;
    logic [2:0]  voice;
    logic [4:0]  note;
    logic        stolen;
    logic [3:0]  von;
    logic        vn_chk;
    logic [19:0] vn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic [7:0] code, logic aoff, logic ev, logic on,
                              logic [2:0] voice, logic [4:0] note, logic stolen, logic [3:0] von);
    vec_t r;
    r.sv = sv; r.code = code; r.aoff = aoff; r.ev = ev; r.on = on;
    r.voice = voice; r.note = note; r.stolen = stolen; r.von = von;
    r.vn_chk = 1'b0; r.vn = '0;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    scan_valid = t.sv;
    scan_code  = t.code;
    all_off    = t.aoff;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    all_off    = 1'b0;
    $display("vec %0d sv=%0b code=%02h aoff=%0b -> evt=%0b on=%0b v=%0d n=%0d st=%0b von=%04b",
             idx, t.sv, t.code, t.aoff, evt_valid, evt_on, evt_voice, evt_note, evt_stolen, voice_on);
    check($sformatf("evt_valid[%0d]", idx), 32'(evt_valid), 32'(t.ev));
    check($sformatf("voice_on[%0d]", idx), 32'(voice_on), 32'(t.von));
    if (t.ev) begin
      check($sformatf("evt_on[%0d]", idx), 32'(evt_on), 32'(t.on));
      check($sformatf("evt_voice[%0d]", idx), 32'(evt_voice), 32'(t.voice));
      check($sformatf("evt_note[%0d]", idx), 32'(evt_note), 32'(t.note));
      check($sformatf("evt_stolen[%0d]", idx), 32'(evt_stolen), 32'(t.stolen));
    end
    if (t.vn_chk) check($sformatf("voice_note[%0d]", idx), 32'(voice_note), 32'(t.vn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    rst = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; all_off = 1'b0;

    // Single key make and break
    vecs.push_back(mk(1, 8'h1C, 0, 1, 1, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1C, 0, 1, 0, 0, 0,  0, 4'b0000));
    // Fill then steal oldest
    vecs.push_back(mk(1, 8'h1C, 0, 1, 1, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1B, 0, 1, 1, 1, 1,  0, 4'b0011));
    vecs.push_back(mk(1, 8'h23, 0, 1, 1, 2, 2,  0, 4'b0111));
    vecs.push_back(mk(1, 8'h2B, 0, 1, 1, 3, 3,  0, 4'b1111));
    vecs.push_back(mk(1, 8'h34, 0, 1, 1, 0, 4,  1, 4'b1111));
    t = mk(1, 8'h33, 0, 1, 1, 1, 5, 1, 4'b1111);
    t.vn_chk = 1'b1; t.vn = {5'd3, 5'd2, 5'd5, 5'd4};
    vecs.push_back(t);
    // Panic alone, then typematic repeat
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  0, 4'b0000));
    vecs.push_back(mk(1, 8'h15, 0, 1, 1, 0, 19, 0, 4'b0001));
    vecs.push_back(mk(1, 8'h15, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h15, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h42, 0, 0, 0, 0, 0,  0, 4'b0001));
    // Extended and non-note filtering
    vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h76, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1C, 0, 1, 1, 1, 0,  0, 4'b0011));
    vecs.push_back(mk(0, 8'h1C, 0, 0, 0, 0, 0,  0, 4'b0011));
    // Panic precedence over a simultaneous scan byte
    vecs.push_back(mk(1, 8'h1B, 0, 1, 1, 2, 1,  0, 4'b0111));
    vecs.push_back(mk(1, 8'h1D, 1, 0, 0, 0, 0,  0, 4'b0000));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0000));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0,  0, 4'b0000));
    // Repeated F0 stays in break state
    vecs.push_back(mk(1, 8'h1C, 0, 1, 1, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h1C, 0, 1, 0, 0, 0,  0, 4'b0000));
    // Break of a non-lowest voice
    vecs.push_back(mk(1, 8'h1B, 0, 1, 1, 0, 1,  0, 4'b0001));
    vecs.push_back(mk(1, 8'h23, 0, 1, 1, 1, 2,  0, 4'b0011));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0011));
    vecs.push_back(mk(1, 8'h23, 0, 1, 0, 1, 2,  0, 4'b0001));
    // Panic discards a pending break prefix
    vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0,  0, 4'b0001));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  0, 4'b0000));
    vecs.push_back(mk(1, 8'h1B, 0, 1, 1, 0, 1,  0, 4'b0001));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_voice_on", 32'(voice_on), 32'h0);
    check("reset_voice_note", 32'(voice_note), 32'h0);
    check("reset_evt", 32'({evt_valid, evt_on, evt_voice, evt_note, evt_stolen}), 32'h0);
    $display("reset: von=%04b vn=%05h evt=%0b", voice_on, voice_note, evt_valid);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-prefix reset: F0 then reset, then 1C must be a make
    apply(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 4'b0001), 100);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_voice_on", 32'(voice_on), 32'h0);
    check("midreset_evt_valid", 32'(evt_valid), 32'h0);
    $display("mid-prefix reset: von=%04b evt=%0b", voice_on, evt_valid);
    apply(mk(1, 8'h1C, 0, 1, 1, 0, 0, 0, 4'b0001), 101);
    // Event strobe lasts a single cycle
    apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0001), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
